// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional build macro ILLEGAL_TRAP_EN: unlisted opcodes enter TRAP and raise
// a sticky illegal flag until reset. Without it they retire as a 2-cycle NOP.
module ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] ALUOp,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       jump,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5,
    RSV6   = 3'd6,
    RSV7   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic is_alu_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_alu_imm(op) || (op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW});
  endfunction

  // Branches and ALU-immediates carry their ALU class in the low opcode nibble.
  function automatic logic [3:0] alu_class(input logic [5:0] op);
    if (op == OP_RTYPE) return 4'b1111;
    if (is_alu_imm(op) || op == OP_BEQ || op == OP_BNE) return op[3:0];
    return 4'b0000;
  endfunction

  state_t     st_q, st_nxt;
  logic [5:0] op_q, op_nxt;
  logic [3:0] n_alu;
  logic       n_mem_read, n_mem_write, n_branch, n_branch_ne, n_jump;
  logic       n_reg_write, n_reg_dst, n_alu_src, n_mem_to_reg;

  // Next state and next latched opcode.
  always_comb begin
    st_nxt = st_q;
    op_nxt = op_q;
    case (st_q)
      FETCH:  if (mem_read && mem_ready) st_nxt = DECODE;
      DECODE: begin
        op_nxt = opcode;
        if (is_legal(opcode)) st_nxt = EXEC;
`ifdef ILLEGAL_TRAP_EN
        else st_nxt = TRAP;
`else
        else st_nxt = FETCH;
`endif
      end
      EXEC: begin
        if (op_q == OP_RTYPE || is_alu_imm(op_q)) st_nxt = WB;
        else if (op_q == OP_LW || op_q == OP_SW) st_nxt = MEM;
        else st_nxt = FETCH;
      end
      MEM:  if (mem_ready) st_nxt = (op_q == OP_LW) ? WB : FETCH;
      WB:   st_nxt = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP: st_nxt = TRAP;
`else
      TRAP: st_nxt = FETCH;
`endif
      default: st_nxt = FETCH;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    n_alu        = '0;
    n_mem_read   = 1'b0;
    n_mem_write  = 1'b0;
    n_branch     = 1'b0;
    n_branch_ne  = 1'b0;
    n_jump       = 1'b0;
    n_reg_write  = 1'b0;
    n_reg_dst    = 1'b0;
    n_alu_src    = 1'b0;
    n_mem_to_reg = 1'b0;
    case (st_nxt)
      FETCH: n_mem_read = 1'b1;
      EXEC: begin
        n_alu       = alu_class(op_nxt);
        n_alu_src   = is_alu_imm(op_nxt) || op_nxt == OP_LW || op_nxt == OP_SW;
        n_branch    = (op_nxt == OP_BEQ) || (op_nxt == OP_BNE);
        n_branch_ne = (op_nxt == OP_BNE);
        n_jump      = (op_nxt == OP_J);
      end
      MEM: begin
        n_mem_read  = (op_nxt == OP_LW);
        n_mem_write = (op_nxt == OP_SW);
      end
      WB: begin
        n_reg_write  = 1'b1;
        n_reg_dst    = (op_nxt == OP_RTYPE);
        n_mem_to_reg = (op_nxt == OP_LW);
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // State, opcode latch and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= FETCH;
      op_q       <= '0;
      ALUOp      <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
      reg_write  <= 1'b0;
      reg_dst    <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      st_q       <= st_nxt;
      op_q       <= op_nxt;
      ALUOp      <= n_alu;
      mem_read   <= n_mem_read;
      mem_write  <= n_mem_write;
      branch     <= n_branch;
      branch_ne  <= n_branch_ne;
      jump       <= n_jump;
      reg_write  <= n_reg_write;
      reg_dst    <= n_reg_dst;
      alu_src    <= n_alu_src;
      mem_to_reg <= n_mem_to_reg;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= (st_nxt == TRAP);
`endif
    end
  end

  // Fetch completion is gated by the registered mem_read, so the first cycle
  // after reset (strobes still low) cannot retire a fetch.
  assign ir_write = (st_q == FETCH) && mem_read && mem_ready && !rst;
  assign pc_write = ir_write;
  assign state    = st_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: scoreboard bench for ctrl_fsm. Per-cycle stimulus and expected
// outputs are queued together and checked as the DUT steps through them.
module tb_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALUOp;
  logic       mem_read, mem_write, ir_write, pc_write, branch, branch_ne, jump;
  logic       reg_write, reg_dst, alu_src, mem_to_reg, illegal;
  logic [2:0] state;

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .branch_ne(branch_ne), .jump(jump), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .state(state), .illegal(illegal)
  );

  localparam logic [10:0] SB_MR = 11'h400, SB_MW = 11'h200, SB_IR = 11'h100, SB_PC = 11'h080;
  localparam logic [10:0] SB_BR = 11'h040, SB_BNE = 11'h020, SB_J = 11'h010, SB_RW = 11'h008;
  localparam logic [10:0] SB_RD = 11'h004, SB_AS = 11'h002, SB_M2R = 11'h001;

  typedef struct packed {
    logic        mr;
    logic [5:0]  op;
    logic [2:0]  st;
    logic [3:0]  alu;
    logic [10:0] sb;
    logic        ill;
  } rec_t;

  rec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // 0 R-type, 1 ALU-imm, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 unlisted
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110: return 1;
      6'b100011: return 2;
      6'b101011: return 3;
      6'b000100: return 4;
      6'b000101: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [5:0] op);
    case (op)
      6'b000000: return 4'b1111;
      6'b000100: return 4'b0100;
      6'b000101: return 4'b0101;
      6'b001000: return 4'b1000;
      6'b001010: return 4'b1010;
      6'b001011: return 4'b1011;
      6'b001100: return 4'b1100;
      6'b001101: return 4'b1101;
      6'b001110: return 4'b1110;
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic [2:0] st,
                      input logic [3:0] alu, input logic [10:0] sbits, input logic ill);
    rec_t r;
    r.mr = mr; r.op = op; r.st = st; r.alu = alu; r.sb = sbits; r.ill = ill;
    sb_q.push_back(r);
  endtask

  // Queue one instruction starting from a live FETCH cycle. The opcode bus
  // carries the complement outside DECODE so stray sampling would be visible.
  task automatic push_instr(input logic [5:0] op, input int fw, input int mw);
    int c;
    logic [10:0] x;
    c = op_class(op);
    repeat (fw) push(1'b0, ~op, 3'd0, 4'd0, SB_MR, 1'b0);
    push(1'b1, ~op, 3'd0, 4'd0, SB_MR | SB_IR | SB_PC, 1'b0);
    push(rb(), op, 3'd1, 4'd0, '0, 1'b0);
    if (c == 7) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (4) push(rb(), ~op, 3'd5, 4'd0, '0, 1'b1);
`endif
      return;
    end
    x = (c == 1 || c == 2 || c == 3) ? SB_AS : 11'h000;
    if (c == 4) x = x | SB_BR;
    if (c == 5) x = x | SB_BR | SB_BNE;
    if (c == 6) x = x | SB_J;
    push(rb(), ~op, 3'd2, exp_alu(op), x, 1'b0);
    if (c == 2 || c == 3) begin
      repeat (mw) push(1'b0, ~op, 3'd3, 4'd0, (c == 2) ? SB_MR : SB_MW, 1'b0);
      push(1'b1, ~op, 3'd3, 4'd0, (c == 2) ? SB_MR : SB_MW, 1'b0);
    end
    if (c == 0 || c == 1 || c == 2)
      push(rb(), ~op, 3'd4, 4'd0,
           SB_RW | ((c == 0) ? SB_RD : 11'h000) | ((c == 2) ? SB_M2R : 11'h000), 1'b0);
  endtask

  task automatic run_n(input int n);
    rec_t r;
    logic [10:0] got;
    for (int i = 0; i < n && sb_q.size() > 0; i++) begin
      r = sb_q.pop_front();
      mem_ready = r.mr;
      opcode = r.op;
      #1;
      got = {mem_read, mem_write, ir_write, pc_write, branch, branch_ne, jump,
             reg_write, reg_dst, alu_src, mem_to_reg};
      tests++;
      if (state !== r.st) begin
        fails++; $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, r.st);
      end
      tests++;
      if (ALUOp !== r.alu) begin
        fails++; $display("FAIL alu_op cyc=%0d got=%b exp=%b", cyc, ALUOp, r.alu);
      end
      tests++;
      if (got !== r.sb) begin
        fails++; $display("FAIL strobes cyc=%0d state=%0d got=%b exp=%b", cyc, state, got, r.sb);
      end
      tests++;
      if (illegal !== r.ill) begin
        fails++; $display("FAIL illegal cyc=%0d got=%b exp=%b", cyc, illegal, r.ill);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_all();
    run_n(sb_q.size());
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h23;
    repeat (2) @(posedge clk);
    #1;
    got = {mem_read, mem_write, ir_write, pc_write, branch, branch_ne, jump,
           reg_write, reg_dst, alu_src, mem_to_reg};
    tests++;
    if (state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests++;
    if (got !== 11'h000) begin fails++; $display("FAIL reset_strobes got=%b exp=0", got); end
    tests++;
    if (ALUOp !== 4'b0000) begin fails++; $display("FAIL reset_alu got=%b exp=0000", ALUOp); end
    tests++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    rst = 1'b0;
    sb_q.delete();
    push(1'b1, 6'h00, 3'd0, 4'd0, '0, 1'b0);
  endtask

  task automatic test_rtype();
    push_instr(6'b000000, 0, 0);
    run_all();
  endtask

  task automatic test_lw_wait();
    push_instr(6'b100011, 0, 3);
    run_all();
  endtask

  task automatic test_bne();
    push_instr(6'b000101, 0, 0);
    run_all();
  endtask

  task automatic test_xori_sw();
    push_instr(6'b001110, 0, 0);
    push_instr(6'b101011, 0, 0);
    run_all();
  endtask

  task automatic test_other_ops();
    logic [5:0] ops[8] = '{6'b000100, 6'b000010, 6'b001000, 6'b001010,
                           6'b001011, 6'b001100, 6'b001101, 6'b000000};
    for (int i = 0; i < 8; i++) push_instr(ops[i], i % 3, 0);
    push_instr(6'b101011, 2, 2);
    run_all();
  endtask

  task automatic test_latency();
    logic [5:0] ops[7] = '{6'b000010, 6'b000100, 6'b000101, 6'b000000,
                           6'b001000, 6'b101011, 6'b100011};
    int lat[7] = '{3, 3, 3, 4, 4, 4, 5};
    int n;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      #1;
      n = 0;
      while (!ir_write && n < 10) begin @(posedge clk); #1; n++; end
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ir_write && n < 20);
      tests++;
      if (n != lat[i]) begin
        fails++; $display("FAIL latency op=%b got=%0d exp=%0d", ops[i], n, lat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    push_instr(6'b101011, 0, 5);
    run_n(5);
    sb_q.delete();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (mem_write !== 1'b1) begin fails++; $display("FAIL mid_mem_pre got=%b exp=1", mem_write); end
    @(posedge clk); #1;
    tests++;
    if (state !== 3'd0) begin fails++; $display("FAIL mid_mem_state got=%0d exp=0", state); end
    tests++;
    if (mem_write !== 1'b0) begin fails++; $display("FAIL mid_mem_mw got=%b exp=0", mem_write); end
    rst = 1'b0;
    push(1'b1, 6'h00, 3'd0, 4'd0, '0, 1'b0);
    push_instr(6'b000000, 0, 0);
    run_all();
  endtask

  task automatic test_illegal();
    push_instr(6'b111111, 0, 0);
    run_all();
`ifdef ILLEGAL_TRAP_EN
    test_reset();
    run_all();
`endif
    push_instr(6'b001101, 1, 0);
    run_all();
  endtask

  initial begin
    #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_bne();
    test_xori_sw();
    test_other_ops();
    test_latency();
    test_reset_mid_mem();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout reached at cyc=%0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
